pipe_mem_ctrl: RTL and testbench

//  Memory-stage sequencer sitting after the EX/MEM pipeline register. Runs each

---
 rtl/pipe_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_mem_ctrl                                                 |
// | Purpose  : MEM-stage load/store sequencer with dmem req/ack handshake,   |
// |            pipeline stall/bubble control, alignment and timeout checks.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipe_mem_ctrl #(
  parameter int TIMEOUT   = 16,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_bubble,
  output logic [31:0] mmo,
  output logic        mem_done,
  input  logic        err_clr,
  output logic        err_misalign,
  output logic        err_bus,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_timer;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [31:0] r_mmo;
  logic        r_err_misalign;
  logic        r_err_bus;
  logic        r_err_timeout;

  logic        w_acc;
  logic        w_misalign;
  logic        w_tmo;
  logic        w_set_mis;
  logic        w_set_bus;
  logic        w_set_to;

  assign w_acc = mm2reg | mwmem;

  // All MEM-stage accesses are word-sized, so any low address bit is a fault.
  generate
    if (ALIGN_CHK) begin : g_align_on
      assign w_misalign = |malu[1:0];
    end else begin : g_align_off
      assign w_misalign = 1'b0;
    end
  endgenerate

  // An ack arriving in the final timeout cycle takes priority over the abort.
  assign w_tmo = ~dmem_ack & (r_timer == C_TMO_LAST);

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    wb_bubble = 1'b0;
    mem_done  = 1'b0;
    w_set_mis = 1'b0;
    w_set_bus = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          // Hold the faulting instruction one cycle so ABORT squashes it.
          stall     = 1'b1;
          wb_bubble = 1'b1;
          if (w_misalign) begin
            w_next    = ST_ABORT;
            w_set_mis = 1'b1;
          end else begin
            w_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall     = 1'b1;
        wb_bubble = 1'b1;
        if (dmem_ack) begin
          if (dmem_err) begin
            w_next    = ST_ABORT;
            w_set_bus = 1'b1;
          end else begin
            w_next = ST_DONE;
          end
        end else if (w_tmo) begin
          w_next   = ST_ABORT;
          w_set_to = 1'b1;
        end
      end
      ST_DONE: begin
        mem_done = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_ABORT: begin
        wb_bubble = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= 8'd0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_mmo        <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_acc && !w_misalign) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= mwmem;
            r_dmem_addr  <= malu;
            r_dmem_wdata <= mb;
            r_timer      <= 8'd0;
          end
        end
        ST_REQ: begin
          r_timer <= r_timer + 8'd1;
          if (dmem_ack || w_tmo) begin
            r_dmem_req <= 1'b0;
          end
          if (dmem_ack && !dmem_err && !r_dmem_we) begin
            r_mmo <= dmem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A new error in the same cycle as err_clr survives the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_misalign <= 1'b0;
      r_err_bus      <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_err_misalign <= w_set_mis | (r_err_misalign & ~err_clr);
      r_err_bus      <= w_set_bus | (r_err_bus & ~err_clr);
      r_err_timeout  <= w_set_to  | (r_err_timeout & ~err_clr);
    end
  end

  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign mmo          = r_mmo;
  assign err_misalign = r_err_misalign;
  assign err_bus      = r_err_bus;
  assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_mem_ctrl                                              |
// | Purpose  : Self-checking bench for pipe_mem_ctrl (vectors, corner        |
// |            sequences, randomized traffic against a transaction model).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pipe_mem_ctrl;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mm2reg = 1'b0;
  logic        mwmem = 1'b0;
  logic [31:0] malu = 32'd0;
  logic [31:0] mb = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        dmem_err = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        err_clr = 1'b0;
  logic        dmem_req, dmem_we, stall, wb_bubble, mem_done;
  logic        err_misalign, err_bus, err_timeout;
  logic [31:0] dmem_addr, dmem_wdata, mmo;

  always #5 clock = ~clock;

  pipe_mem_ctrl #(.TIMEOUT(TMO), .ALIGN_CHK(1'b1)) dut (
    .clock(clock), .reset(reset), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_err(dmem_err), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_bubble(wb_bubble), .mmo(mmo), .mem_done(mem_done), .err_clr(err_clr),
    .err_misalign(err_misalign), .err_bus(err_bus), .err_timeout(err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an access is either waiting (with an age)
  // or has just finished with an outcome that is visible for one cycle.
  typedef struct {
    bit          busy;
    int          age;
    int          fin;     // 0 none, 1 completed, 2 squashed
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mmo;
    bit          emis;
    bit          ebus;
    bit          eto;
  } model_t;

  model_t mdl = '{default: 0};

  function automatic model_t step(input model_t m);
    model_t n = m;
    bit hit_mis = 1'b0;
    bit hit_bus = 1'b0;
    bit hit_to  = 1'b0;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    if (m.fin != 0) begin
      n.fin = 0;
    end else if (m.busy) begin
      n.age = m.age + 1;
      if (dmem_ack) begin
        n.busy = 1'b0;
        n.req  = 1'b0;
        if (dmem_err) begin
          n.fin = 2;
          hit_bus = 1'b1;
        end else begin
          n.fin = 1;
          if (!m.we) n.mmo = dmem_rdata;
        end
      end else if (n.age == TMO) begin
        n.busy = 1'b0;
        n.req  = 1'b0;
        n.fin  = 2;
        hit_to = 1'b1;
      end
    end else if (mm2reg || mwmem) begin
      if (malu[1:0] != 2'b00) begin
        n.fin = 2;
        hit_mis = 1'b1;
      end else begin
        n.busy  = 1'b1;
        n.age   = 0;
        n.req   = 1'b1;
        n.we    = mwmem;
        n.addr  = malu;
        n.wdata = mb;
      end
    end
    n.emis = hit_mis || (m.emis && !err_clr);
    n.ebus = hit_bus || (m.ebus && !err_clr);
    n.eto  = hit_to  || (m.eto  && !err_clr);
    return n;
  endfunction

  // {stall, wb_bubble, mem_done} for the current cycle
  function automatic logic [2:0] exp_comb(input model_t m);
    if (m.fin == 1) return 3'b001;
    if (m.fin == 2) return 3'b010;
    if (m.busy || mm2reg || mwmem) return 3'b110;
    return 3'b000;
  endfunction

  always @(posedge clock) mdl <= step(mdl);

  task automatic chk_model();
    logic [2:0] e;
    e = exp_comb(mdl);
    chk("rnd.stall", stall, e[2]);
    chk("rnd.bubble", wb_bubble, e[1]);
    chk("rnd.done", mem_done, e[0]);
    chk("rnd.req", dmem_req, mdl.req);
    chk("rnd.mmo", mmo, mdl.mmo);
    chk("rnd.errs", {err_misalign, err_bus, err_timeout}, {mdl.emis, mdl.ebus, mdl.eto});
    if (mdl.req) begin
      chk("rnd.we", dmem_we, mdl.we);
      chk("rnd.addr", dmem_addr, mdl.addr);
      chk("rnd.wdata", dmem_wdata, mdl.wdata);
    end
  endtask

  typedef struct {
    logic rst, ld, st, ack, err, clr;
    logic [31:0] addr, wd, rd;
    logic stall, bub, done, req;
    logic [31:0] mmo;
    logic [2:0] errs;  // {misalign, bus, timeout}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, ld, st, input logic [31:0] addr, wd,
                     input logic ack, err, input logic [31:0] rd, input logic clr,
                     input logic e_stall, e_bub, e_done, e_req,
                     input logic [31:0] e_mmo, input logic [2:0] e_errs);
    vec_t v;
    v.rst = rst; v.ld = ld; v.st = st; v.addr = addr; v.wd = wd;
    v.ack = ack; v.err = err; v.rd = rd; v.clr = clr;
    v.stall = e_stall; v.bub = e_bub; v.done = e_done; v.req = e_req;
    v.mmo = e_mmo; v.errs = e_errs;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    int cnt, win, dones;
    bit got_done, prev;

    //   rst ld st addr    wd     ack err rd            clr  stall bub done req mmo  errs
    add(1, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 0, 0, 32'h0, 3'b000);
    add(0, 1, 0, 32'h10, 32'h0,    0, 0, 32'h0,         0,   1, 1, 0, 0, 32'h0, 3'b000);
    add(0, 1, 0, 32'h10, 32'h0,    0, 0, 32'h0,         0,   1, 1, 0, 1, 32'h0, 3'b000);
    add(0, 1, 0, 32'h10, 32'h0,    1, 0, DB,            0,   1, 1, 0, 1, 32'h0, 3'b000);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 1, 0, DB,    3'b000);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 0, 0, DB,    3'b000);
    add(0, 0, 1, 32'h20, 32'h55AA, 0, 0, 32'h0,         0,   1, 1, 0, 0, DB,    3'b000);
    add(0, 0, 1, 32'h20, 32'h55AA, 0, 0, 32'h0,         0,   1, 1, 0, 1, DB,    3'b000);
    add(0, 0, 1, 32'h20, 32'h55AA, 1, 0, 32'h12345678,  0,   1, 1, 0, 1, DB,    3'b000);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 1, 0, DB,    3'b000);
    add(0, 1, 0, 32'h13, 32'h0,    0, 0, 32'h0,         0,   1, 1, 0, 0, DB,    3'b000);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 1, 0, 0, DB,    3'b100);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 0, 0, DB,    3'b100);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         1,   0, 0, 0, 0, DB,    3'b100);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 0, 0, DB,    3'b000);
    add(0, 1, 0, 32'h40, 32'h0,    0, 0, 32'h0,         0,   1, 1, 0, 0, DB,    3'b000);
    add(0, 1, 0, 32'h40, 32'h0,    1, 1, 32'hBAD0BAD0,  0,   1, 1, 0, 1, DB,    3'b000);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 1, 0, 0, DB,    3'b010);
    add(0, 1, 0, 32'h44, 32'h0,    0, 0, 32'h0,         0,   1, 1, 0, 0, DB,    3'b010);
    add(0, 1, 0, 32'h44, 32'h0,    1, 1, 32'h0,         1,   1, 1, 0, 1, DB,    3'b010);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 1, 0, 0, DB,    3'b010);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         1,   0, 0, 0, 0, DB,    3'b010);
    add(0, 0, 0, 32'h00, 32'h0,    0, 0, 32'h0,         0,   0, 0, 0, 0, DB,    3'b000);

    repeat (2) @(posedge clock);
    #1;

    foreach (tbl[i]) begin
      reset = tbl[i].rst; mm2reg = tbl[i].ld; mwmem = tbl[i].st;
      malu = tbl[i].addr; mb = tbl[i].wd; dmem_ack = tbl[i].ack;
      dmem_err = tbl[i].err; dmem_rdata = tbl[i].rd; err_clr = tbl[i].clr;
      @(negedge clock);
      chk($sformatf("vec%0d.stall", i), stall, tbl[i].stall);
      chk($sformatf("vec%0d.bubble", i), wb_bubble, tbl[i].bub);
      chk($sformatf("vec%0d.done", i), mem_done, tbl[i].done);
      chk($sformatf("vec%0d.req", i), dmem_req, tbl[i].req);
      chk($sformatf("vec%0d.mmo", i), mmo, tbl[i].mmo);
      chk($sformatf("vec%0d.errs", i), {err_misalign, err_bus, err_timeout}, tbl[i].errs);
      if (tbl[i].req) begin
        chk($sformatf("vec%0d.addr", i), dmem_addr, tbl[i].addr);
        chk($sformatf("vec%0d.wdata", i), dmem_wdata, tbl[i].wd);
        chk($sformatf("vec%0d.we", i), dmem_we, tbl[i].st);
      end
      @(posedge clock);
      #1;
    end
    reset = 0; mm2reg = 0; mwmem = 0; dmem_ack = 0; dmem_err = 0; err_clr = 0;

    // Timeout with no ack: request window must be exactly TMO cycles.
    mm2reg = 1; malu = 32'h80; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (dmem_req) cnt++;
      else if (cnt > 0) break;
      @(posedge clock);
      #1;
    end
    chk("tmo.req_cycles", cnt, TMO);
    chk("tmo.err", err_timeout, 1'b1);
    chk("tmo.stall", stall, 1'b0);
    chk("tmo.bubble", wb_bubble, 1'b1);
    chk("tmo.done", mem_done, 1'b0);
    mm2reg = 0;
    @(posedge clock); #1;
    err_clr = 1;
    @(posedge clock); #1;
    err_clr = 0;

    // Ack in the last timeout cycle wins.
    mm2reg = 1; malu = 32'h84; dmem_rdata = 32'hA5A50004; cnt = 0; got_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (mem_done) begin
        got_done = 1;
        break;
      end
      if (dmem_req) cnt++;
      dmem_ack = (cnt == TMO);
      @(posedge clock);
      #1;
    end
    chk("lastack.done", got_done, 1'b1);
    chk("lastack.req_cycles", cnt, TMO);
    chk("lastack.err", err_timeout, 1'b0);
    chk("lastack.mmo", mmo, 32'hA5A50004);
    dmem_ack = 0; mm2reg = 0;
    @(posedge clock); #1;

    // Reset in the middle of a request; a late ack must be ignored.
    mm2reg = 1; malu = 32'h100;
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0; mm2reg = 0;
    @(negedge clock);
    chk("rst.req", dmem_req, 1'b0);
    chk("rst.stall", stall, 1'b0);
    chk("rst.mmo", mmo, 32'h0);
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    dmem_ack = 0;
    @(negedge clock);
    chk("lateack.mmo", mmo, 32'h0);
    chk("lateack.done", mem_done, 1'b0);
    chk("lateack.req", dmem_req, 1'b0);
    @(posedge clock); #1;

    // Back-to-back loads produce two distinct request windows.
    mm2reg = 1; malu = 32'h200; win = 0; dones = 0; prev = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (dmem_req && !prev) win++;
      prev = dmem_req;
      if (mem_done) dones++;
      if (dones == 2) break;
      dmem_ack = dmem_req;
      dmem_rdata = 32'h10000000 + 32'(win);
      @(posedge clock);
      #1;
    end
    chk("b2b.windows", win, 2);
    chk("b2b.dones", dones, 2);
    chk("b2b.mmo", mmo, 32'h10000002);
    mm2reg = 0; dmem_ack = 0;
    @(posedge clock); #1;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      int op;
      logic [31:0] a;
      reset = ($urandom_range(99) < 2);
      op = $urandom_range(3);
      mm2reg = (op == 1);
      mwmem = (op == 2);
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      malu = a;
      mb = $urandom;
      dmem_ack = ($urandom_range(99) < 35);
      dmem_err = ($urandom_range(99) < 20);
      dmem_rdata = $urandom;
      err_clr = ($urandom_range(99) < 8);
      @(negedge clock);
      chk_model();
      @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
